// File: rtl/arriskv_pkg.sv
// Shared types for the decode stage: opcode encodings, instruction kinds and
// the decoded-operation record handed to execute.
package arriskv_pkg;

    // Widest supported datapath; narrower instances extend into these fields.
    localparam int OP_XLEN = 64;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        TYPE_R,
        TYPE_I,
        TYPE_S,
        TYPE_B,
        TYPE_U,
        TYPE_J,
        TYPE_X
    } instr_type_t;

    typedef enum logic [4:0] {
        NOP,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM
    } instruction_t;

    typedef struct packed {
        instruction_t         instruction;
        instr_type_t          itype;
        logic [6:0]           opcode;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [OP_XLEN-1:0]   imm;
        logic [OP_XLEN-1:0]   pc;
        logic [OP_XLEN-1:0]   rs1_data;
        logic [OP_XLEN-1:0]   rs2_data;
        logic                 illegal;
    } operation_t;

endpackage

// File: rtl/decode_fifo.sv
// In-order buffer between decode and execute with valid/ready on both sides.
// Flush empties it and swallows any same-cycle push.
module decode_fifo
    import arriskv_pkg::*;
#(
    parameter int  DEPTH     = 2,
    parameter type payload_t = operation_t
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_flush,
    input  logic     i_valid,
    output logic     o_ready,
    input  payload_t i_data,
    output logic     o_valid,
    input  logic     i_ready,
    output payload_t o_data
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    payload_t      mem_q [DEPTH];
    logic          full, empty, push, pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push    = i_valid && !full && !i_flush;
    assign pop     = !empty && i_ready && !i_flush;
    assign o_ready = !full;
    assign o_valid = !empty;
    assign o_data  = mem_q[rd_ptr_q[PW-2:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PW-2:0]] <= i_data;
    end

endmodule

// File: rtl/decode_stage.sv
// RV decode: combinational field/immediate/operation decode with operand
// capture, buffered in order towards execute.
module decode_stage
    import arriskv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int N_REGS = 32,
    parameter int DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_flush,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [XLEN-1:0]               i_pc,
    input  logic [31:0]                   i_instr,
    output logic [2*$clog2(N_REGS)-1:0]   o_reg_rd_addr,
    input  logic [2*XLEN-1:0]             i_reg_rd_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output operation_t                    o_decoded
);

    localparam int AW = $clog2(N_REGS);

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
    logic [31:0]     imm_u32;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic            shift_f7_ok;
    logic            illegal;
    instruction_t    instruction;
    instr_type_t     itype;
    operation_t      dec;

    assign o_reg_rd_addr = {AW'(i_instr[24:20]), AW'(i_instr[19:15])};

    assign funct7      = i_instr[31:25];
    assign funct3      = i_instr[14:12];
    assign shift_f7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

    assign imm_u32 = {i_instr[31:12], 12'b0};
    assign imm_i   = XLEN'($signed(i_instr[31:20]));
    assign imm_s   = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
    assign imm_b   = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                    i_instr[11:8], 1'b0}));
    assign imm_u   = XLEN'($signed(imm_u32));
    assign imm_j   = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                    i_instr[30:21], 1'b0}));

    always_comb begin
        instruction = NOP;
        itype       = TYPE_X;
        imm_sel     = '0;
        illegal     = 1'b0;
        case (i_instr[6:0])
            OPC_OP: begin
                itype = TYPE_R;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  instruction = ADD;
                            3'b001:  instruction = SLL;
                            3'b010:  instruction = SLT;
                            3'b011:  instruction = SLTU;
                            3'b100:  instruction = XOR;
                            3'b101:  instruction = SRL;
                            3'b110:  instruction = OR;
                            default: instruction = AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      instruction = SUB;
                        else if (funct3 == 3'b101) instruction = SRA;
                        else                       illegal     = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                itype   = TYPE_I;
                imm_sel = imm_i;
                case (funct3)
                    3'b000:  instruction = ADDI;
                    3'b001: begin
                        instruction = SLLI;
                        illegal     = !shift_f7_ok;
                    end
                    3'b010:  instruction = SLTI;
                    3'b011:  instruction = SLTIU;
                    3'b100:  instruction = XORI;
                    3'b101: begin
                        instruction = i_instr[30] ? SRAI : SRLI;
                        illegal     = !shift_f7_ok;
                    end
                    3'b110:  instruction = ORI;
                    default: instruction = ANDI;
                endcase
            end
            OPC_LOAD:   begin itype = TYPE_I; imm_sel = imm_i; instruction = LOAD;   end
            OPC_STORE:  begin itype = TYPE_S; imm_sel = imm_s; instruction = STORE;  end
            OPC_BRANCH: begin itype = TYPE_B; imm_sel = imm_b; instruction = BRANCH; end
            OPC_LUI:    begin itype = TYPE_U; imm_sel = imm_u; instruction = LUI;    end
            OPC_AUIPC:  begin itype = TYPE_U; imm_sel = imm_u; instruction = AUIPC;  end
            OPC_JAL:    begin itype = TYPE_J; imm_sel = imm_j; instruction = JAL;    end
            OPC_JALR:   begin itype = TYPE_I; imm_sel = imm_i; instruction = JALR;   end
            OPC_SYSTEM: begin itype = TYPE_I; imm_sel = imm_i; instruction = SYSTEM; end
            default:    illegal = 1'b1;
        endcase
        if (i_instr[1:0] != 2'b11) illegal = 1'b1;
        // Illegal entries still flow to execute, but as a harmless NOP.
        if (illegal) instruction = NOP;
    end

    always_comb begin
        dec             = '0;
        dec.instruction = instruction;
        dec.itype       = itype;
        dec.opcode      = i_instr[6:0];
        dec.rd          = i_instr[11:7];
        dec.rs1         = i_instr[19:15];
        dec.rs2         = i_instr[24:20];
        dec.funct3      = funct3;
        dec.funct7      = funct7;
        dec.imm         = OP_XLEN'($signed(imm_sel));
        dec.pc          = OP_XLEN'(i_pc);
        dec.rs1_data    = (i_instr[19:15] == 5'd0) ? '0 : OP_XLEN'(i_reg_rd_data[XLEN-1:0]);
        dec.rs2_data    = (i_instr[24:20] == 5'd0) ? '0 : OP_XLEN'(i_reg_rd_data[2*XLEN-1:XLEN]);
        dec.illegal     = illegal;
    end

    decode_fifo #(
        .DEPTH     (DEPTH),
        .payload_t (operation_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (dec),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_decoded)
    );

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage at XLEN=64, DEPTH=2.
module tb_decode_stage;
    import arriskv_pkg::*;

    localparam int XLEN   = 64;
    localparam int N_REGS = 32;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_flush = 1'b0;
    logic              i_valid = 1'b0;
    logic              i_ready = 1'b0;
    logic              o_ready;
    logic              o_valid;
    logic [XLEN-1:0]   i_pc = '0;
    logic [31:0]       i_instr = '0;
    logic [9:0]        o_reg_rd_addr;
    logic [2*XLEN-1:0] i_reg_rd_data = '0;
    operation_t        o_decoded;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage #(
        .XLEN   (XLEN),
        .N_REGS (N_REGS),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_pc          (i_pc),
        .i_instr       (i_instr),
        .o_reg_rd_addr (o_reg_rd_addr),
        .i_reg_rd_data (i_reg_rd_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_decoded     (o_decoded)
    );

    always @(posedge clk) begin
        if (rst_n && o_valid && i_ready)
            $display("deliver pc=%h instr=%0d illegal=%0b imm=%h",
                     o_decoded.pc, o_decoded.instruction, o_decoded.illegal, o_decoded.imm);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        i_instr = ins;
        i_pc    = pc;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_o_valid", 64'(o_valid), 64'd0);
        chk("reset_o_ready", 64'(o_ready), 64'd1);
        #10 rst_n = 1'b1;
        tick();

        // Single instructions, execute always ready
        i_ready       = 1'b1;
        i_reg_rd_data = {64'd7, 64'd9};
        i_instr       = 32'h0050_0093;
        #1;
        chk("rd_addr", 64'(o_reg_rd_addr), 64'h0A0);
        send(32'h0050_0093, 64'h1000);
        chk("addi_valid", 64'(o_valid), 64'd1);
        chk("addi_instr", 64'(o_decoded.instruction), 64'(ADDI));
        chk("addi_rd", 64'(o_decoded.rd), 64'd1);
        chk("addi_imm", o_decoded.imm, 64'd5);
        chk("addi_rs1_x0", o_decoded.rs1_data, 64'd0);
        chk("addi_rs2_data", o_decoded.rs2_data, 64'd7);
        chk("addi_illegal", 64'(o_decoded.illegal), 64'd0);
        chk("addi_pc", o_decoded.pc, 64'h1000);

        send(32'hFFF0_0113, 64'h1004);
        chk("addim1_imm", o_decoded.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addim1_rd", 64'(o_decoded.rd), 64'd2);

        send(32'h4020_81B3, 64'h1008);
        chk("sub_instr", 64'(o_decoded.instruction), 64'(SUB));
        chk("sub_type", 64'(o_decoded.itype), 64'(TYPE_R));
        chk("sub_rs1_data", o_decoded.rs1_data, 64'd9);
        chk("sub_rs2_data", o_decoded.rs2_data, 64'd7);
        chk("sub_imm", o_decoded.imm, 64'd0);

        send(32'h0020_A423, 64'h100C);
        chk("sw_imm", o_decoded.imm, 64'd8);
        chk("sw_type", 64'(o_decoded.itype), 64'(TYPE_S));

        send(32'h8000_02B7, 64'h1010);
        chk("lui_instr", 64'(o_decoded.instruction), 64'(LUI));
        chk("lui_imm", o_decoded.imm, 64'hFFFF_FFFF_8000_0000);
        tick();
        chk("drain_empty", 64'(o_valid), 64'd0);

        // Illegal instruction flows in order between legal ones
        send(32'h0050_0093, 64'h100);
        chk("ord0_pc", o_decoded.pc, 64'h100);
        send(32'hFFFF_FFFF, 64'h104);
        chk("ill_pc", o_decoded.pc, 64'h104);
        chk("ill_flag", 64'(o_decoded.illegal), 64'd1);
        chk("ill_nop", 64'(o_decoded.instruction), 64'(NOP));
        send(32'h0050_0093, 64'h108);
        chk("ord2_pc", o_decoded.pc, 64'h108);
        chk("ord2_legal", 64'(o_decoded.illegal), 64'd0);
        tick();
        chk("ill_drain", 64'(o_valid), 64'd0);

        // Backpressure: third push held until space frees
        i_ready = 1'b0;
        i_instr = 32'h0050_0093;
        i_valid = 1'b1;
        i_pc    = 64'h200;
        tick();
        chk("bp_valid", 64'(o_valid), 64'd1);
        chk("bp_ready1", 64'(o_ready), 64'd1);
        i_pc = 64'h204;
        tick();
        chk("bp_full", 64'(o_ready), 64'd0);
        chk("bp_head_a", o_decoded.pc, 64'h200);
        i_pc = 64'h208;
        tick();
        chk("bp_still_full", 64'(o_ready), 64'd0);
        chk("bp_head_stable", o_decoded.pc, 64'h200);
        i_ready = 1'b1;
        tick();
        chk("bp_head_b", o_decoded.pc, 64'h204);
        chk("bp_ready_again", 64'(o_ready), 64'd1);
        tick();
        i_valid = 1'b0;
        chk("bp_head_c", o_decoded.pc, 64'h208);
        chk("bp_c_valid", 64'(o_valid), 64'd1);
        tick();
        chk("bp_empty", 64'(o_valid), 64'd0);

        // Flush with full buffer plus incoming instruction
        i_ready = 1'b0;
        send(32'h0050_0093, 64'h500);
        send(32'h0050_0093, 64'h504);
        chk("fl_full", 64'(o_ready), 64'd0);
        i_pc    = 64'h508;
        i_valid = 1'b1;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("fl_valid", 64'(o_valid), 64'd0);
        chk("fl_ready", 64'(o_ready), 64'd1);
        i_ready = 1'b1;
        tick();
        chk("fl_nothing", 64'(o_valid), 64'd0);

        // Reset with two buffered entries
        i_ready = 1'b0;
        send(32'h0050_0093, 64'h600);
        send(32'h0050_0093, 64'h604);
        chk("rst_pre_valid", 64'(o_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(o_valid), 64'd0);
        chk("rst_async_ready", 64'(o_ready), 64'd1);
        tick();
        #2 rst_n = 1'b1;
        i_ready = 1'b1;
        tick();
        chk("rst_post_empty", 64'(o_valid), 64'd0);
        send(32'h0050_0093, 64'h700);
        chk("rst_first_valid", 64'(o_valid), 64'd1);
        chk("rst_first_pc", o_decoded.pc, 64'h700);
        tick();
        chk("rst_final_empty", 64'(o_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
